// File: rtl/modn_div_ctrl.sv
// Sequencer for a 4-bit loadable counter stage: divide-by-(N+1) tick generator with burst/continuous
// modes, terminal-count detection and a sticky flag for a counter that wrapped instead of reloading.
module modn_div_ctrl #(
  parameter int BW = 8
) (
  input  logic          CP,
  input  logic          clr,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    N,
  input  logic [BW-1:0] BURST,
  input  logic [3:0]    ctr_Q,
  input  logic          ctr_RCO,
  output logic          ctr_n_clr,
  output logic          ctr_n_load,
  output logic          ctr_ENP,
  output logic          ctr_ENT,
  output logic [3:0]    ctr_D,
  output logic          tick,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRELOAD = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    n_lat_q, n_lat_d;
  logic [BW-1:0] burst_lat_q, burst_lat_d;
  logic [BW-1:0] remaining_q, remaining_d;
  logic          tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_comb begin
    state_d     = state_q;
    n_lat_d     = n_lat_q;
    burst_lat_d = burst_lat_q;
    remaining_d = remaining_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_PRELOAD;
          n_lat_d     = N;
          burst_lat_d = BURST;
          remaining_d = BURST;
        end
      end
      S_PRELOAD: state_d = S_RUN;
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (ctr_Q == 4'hF) begin
          tick_d = 1'b1;
          if (burst_lat_q != '0) begin
            remaining_d = remaining_q - BW'(1);
            if (remaining_q == BW'(1)) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    err_d  = err_q | ((state_q == S_RUN) & ctr_RCO);
  end

  always_ff @(posedge CP) begin
    if (clr) begin
      state_q     <= S_IDLE;
      n_lat_q     <= '0;
      burst_lat_q <= '0;
      remaining_q <= '0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_lat_q     <= n_lat_d;
      burst_lat_q <= burst_lat_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // A stop in RUN also drops the enables/load so the counter freezes where it is.
  always_comb begin
    ctr_n_load = 1'b1;
    ctr_ENP    = 1'b0;
    case (state_q)
      S_PRELOAD: ctr_n_load = 1'b0;
      S_RUN: begin
        if (!stop) begin
          ctr_ENP    = 1'b1;
          ctr_n_load = (ctr_Q != 4'hF);
        end
      end
      default: ;
    endcase
  end

  assign ctr_ENT   = ctr_ENP;
  assign ctr_n_clr = ~clr;
  assign ctr_D     = ~n_lat_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_modn_div_ctrl.sv
// Bench for modn_div_ctrl: behavioural counter stage plus a timing-arithmetic reference model.
module tb_modn_div_ctrl;

  logic       CP = 1'b0;
  logic       clr, start, stop, fault;
  logic [3:0] N;
  logic [7:0] BURST;
  logic [3:0] ctr_Q = 4'h0;
  logic       ctr_RCO = 1'b0;
  logic       ctr_n_clr, ctr_n_load, ctr_ENP, ctr_ENT;
  logic [3:0] ctr_D;
  logic       tick, busy, done, err;

  int checks = 0, failures = 0, tick_cnt = 0;

  modn_div_ctrl #(.BW(8)) dut (
    .CP(CP), .clr(clr), .start(start), .stop(stop), .N(N), .BURST(BURST),
    .ctr_Q(ctr_Q), .ctr_RCO(ctr_RCO), .ctr_n_clr(ctr_n_clr), .ctr_n_load(ctr_n_load),
    .ctr_ENP(ctr_ENP), .ctr_ENT(ctr_ENT), .ctr_D(ctr_D), .tick(tick), .busy(busy),
    .done(done), .err(err)
  );

  always #5 CP = ~CP;

  // Counter stage; RCO pulses the cycle after a 15->0 wrap. fault makes it ignore load while enabled.
  always @(posedge CP) begin
    if (!ctr_n_clr) begin
      ctr_Q <= 4'h0; ctr_RCO <= 1'b0;
    end else if (!ctr_n_load && !(fault && ctr_ENP && ctr_ENT)) begin
      ctr_Q <= ctr_D; ctr_RCO <= 1'b0;
    end else if (ctr_ENP && ctr_ENT) begin
      ctr_Q <= ctr_Q + 4'd1; ctr_RCO <= (ctr_Q == 4'hF);
    end else begin
      ctr_RCO <= 1'b0;
    end
  end

  // Reference: ticks fall at edges start+2+N+k*(N+1), k < BURST; aborts on stop/clr.
  int         cyc = 0, m_c0 = 0, mk = 0, mr = 0, mp = 0;
  bit         m_act = 0, m_pend = 0;
  logic [3:0] m_n = 4'h0;
  logic [7:0] m_b = 8'h0;
  bit         e_tick = 0, e_done = 0, e_busy = 0, e_err = 0;

  always @(posedge CP) begin
    cyc++;
    e_tick = 0;
    e_done = 0;
    if (clr) begin
      m_act = 0; m_pend = 0; e_err = 0;
    end else if (m_act) begin
      mk = cyc - m_c0;
      mp = int'(m_n) + 1;
      if (m_pend) begin
        m_act = 0; m_pend = 0;
      end else if (mk >= 2) begin
        if (ctr_RCO === 1'b1) e_err = 1;
        if (stop) m_act = 0;
        else begin
          mr = mk - 1 - mp;
          if (mr >= 0 && (mr % mp) == 0) begin
            e_tick = 1;
            if (m_b != 0 && (mr / mp) == int'(m_b) - 1) begin
              e_done = 1; m_pend = 1;
            end
          end
        end
      end
    end else if (start) begin
      m_act = 1; m_c0 = cyc; m_n = N; m_b = BURST;
    end
    e_busy = m_act;
  end

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] exp_d;
    logic       exp_nclr;
    @(posedge CP);
    @(negedge CP);
    exp_nclr = ~clr;
    chk("tick", {7'b0, tick}, {7'b0, e_tick});
    chk("done", {7'b0, done}, {7'b0, e_done});
    chk("busy", {7'b0, busy}, {7'b0, e_busy});
    chk("err", {7'b0, err}, {7'b0, e_err});
    chk("n_clr", {7'b0, ctr_n_clr}, {7'b0, exp_nclr});
    if (e_busy) begin
      exp_d = {4'b0, ~m_n};
      chk("ctr_D", {4'b0, ctr_D}, exp_d);
    end
    if (tick === 1'b1) tick_cnt++;
  endtask

  task automatic run_idle(int max);
    int i = 0;
    do begin step(); i++; end while (e_busy && i < max);
    chk("idle_timeout", {7'b0, busy}, 8'd0);
  endtask

  task automatic kick(logic [3:0] n, logic [7:0] b);
    N = n; BURST = b; start = 1; tick_cnt = 0;
    step();
    start = 0;
  endtask

  initial begin
    int lat, len;
    clr = 1; start = 0; stop = 0; fault = 0; N = 0; BURST = 0;
    // 1: reset
    step(); step();
    chk("n_clr_in_reset", {7'b0, ctr_n_clr}, 8'd0);
    clr = 0;
    step();
    chk("idle_n_load", {7'b0, ctr_n_load}, 8'd1);
    chk("idle_enp", {7'b0, ctr_ENP}, 8'd0);
    chk("idle_ent", {7'b0, ctr_ENT}, 8'd0);

    // 2: N=3 burst of 4
    kick(4'd3, 8'd4);
    chk("preload_D", {4'b0, ctr_D}, 8'h0C);
    N = 4'd9; BURST = 8'd77;
    lat = 0;
    while (tick !== 1'b1 && lat < 20) begin step(); lat++; end
    chk("first_tick_lat", 8'(lat), 8'd5);
    run_idle(40);
    chk("burst4_ticks", 8'(tick_cnt), 8'd4);

    // 3: N=0 burst of 3
    kick(4'd0, 8'd3);
    run_idle(20);
    chk("n0_ticks", 8'(tick_cnt), 8'd3);
    chk("n0_err", {7'b0, err}, 8'd0);

    // 4: continuous, stop on terminal count
    kick(4'd15, 8'd0);
    for (int i = 0; i < 60 && tick_cnt < 2; i++) step();
    chk("cont_ticks", 8'(tick_cnt), 8'd2);
    for (int i = 0; i < 20 && ctr_Q != 4'hF; i++) step();
    stop = 1;
    step();
    stop = 0;
    chk("stop_busy", {7'b0, busy}, 8'd0);
    chk("stop_q", {4'b0, ctr_Q}, 8'h0F);
    step(); step();
    chk("stop_q_held", {4'b0, ctr_Q}, 8'h0F);
    chk("stop_ticks", 8'(tick_cnt), 8'd2);

    // 5: clr mid-burst, then restart
    kick(4'd2, 8'd10);
    for (int i = 0; i < 40 && tick_cnt < 3; i++) step();
    clr = 1;
    step();
    chk("midrun_n_clr", {7'b0, ctr_n_clr}, 8'd0);
    chk("midrun_busy", {7'b0, busy}, 8'd0);
    clr = 0;
    repeat (8) step();
    chk("midrun_ticks", 8'(tick_cnt), 8'd3);
    kick(4'd2, 8'd10);
    run_idle(60);
    chk("restart_ticks", 8'(tick_cnt), 8'd10);

    // 6: counter ignores reload -> sticky err
    fault = 1;
    kick(4'd15, 8'd3);
    run_idle(100);
    chk("fault_ticks", 8'(tick_cnt), 8'd3);
    chk("fault_err", {7'b0, err}, 8'd1);
    repeat (3) step();
    chk("fault_err_sticky", {7'b0, err}, 8'd1);
    fault = 0;
    clr = 1;
    step();
    clr = 0;
    step();
    chk("err_cleared", {7'b0, err}, 8'd0);

    // random runs with noisy inputs
    for (int it = 0; it < 25; it++) begin
      N = 4'($urandom_range(0, 15));
      BURST = 8'($urandom_range(0, 4));
      stop = 1'($urandom_range(0, 1));
      start = 1;
      step();
      start = 0; stop = 0;
      len = $urandom_range(5, 60);
      for (int j = 0; j < len; j++) begin
        N = 4'($urandom);
        BURST = 8'($urandom_range(0, 4));
        stop = ($urandom_range(0, 15) == 0);
        start = ($urandom_range(0, 7) == 0);
        step();
      end
      start = 0; stop = 1;
      repeat (3) step();
      stop = 0;
      step();
      chk("rand_idle", {7'b0, busy}, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
